// File: rtl/bitstream_decoder.sv
// bitstream_decoder: turns a pair of stochastic bit streams (positive and
// negative channel) into a signed estimate, count_p - count_m, over windows
// of 2^WINDOW_LOG2 accepted samples. Each finished estimate is held in a
// one-entry output register with a valid/ready handshake.
//
// Optional feature: define BITSTREAM_DECODER_OVERRUN_FLAG_EN to build the
// sticky overrun flag. A window that completes while the previous estimate
// is still unconsumed then sets the flag until reset. With the macro
// undefined, overrun is tied low and has no register.
module bitstream_decoder #(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    input  logic                   in_p,
    input  logic                   in_m,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WINDOW_LOG2+1:0] out_value,
    output logic                   overrun
);

    // A counter reaches at most 2^WINDOW_LOG2, so it needs one bit more than idx.
    localparam int unsigned CntW = WINDOW_LOG2 + 1;
    localparam int unsigned OutW = WINDOW_LOG2 + 2;

    logic [CntW-1:0]        count_p_q, count_p_d;
    logic [CntW-1:0]        count_m_q, count_m_d;
    logic [WINDOW_LOG2-1:0] idx_q, idx_d;
    logic [OutW-1:0]        out_value_q, out_value_d;
    logic                   out_valid_q, out_valid_d;

    logic            accept;
    logic            last;
    logic [CntW-1:0] count_p_inc;
    logic [CntW-1:0] count_m_inc;
    logic [OutW-1:0] diff;

    // A sample is accepted only when it is not being discarded by clear.
    // Its counts are folded into the estimate of the window it completes.
    always_comb begin
        accept      = in_valid && !clear;
        last        = accept && (idx_q == {WINDOW_LOG2{1'b1}});
        count_p_inc = count_p_q + CntW'(in_p);
        count_m_inc = count_m_q + CntW'(in_m);
        // Zero-extend before subtracting so that +/-2^WINDOW_LOG2 both fit.
        diff        = {1'b0, count_p_inc} - {1'b0, count_m_inc};
    end

    // Window accumulation: clear wins over both accumulation and completion.
    always_comb begin
        count_p_d = count_p_q;
        count_m_d = count_m_q;
        idx_d     = idx_q;
        if (clear) begin
            count_p_d = '0;
            count_m_d = '0;
            idx_d     = '0;
        end else if (last) begin
            count_p_d = '0;
            count_m_d = '0;
            idx_d     = '0;
        end else if (accept) begin
            count_p_d = count_p_inc;
            count_m_d = count_m_inc;
            idx_d     = idx_q + WINDOW_LOG2'(1);
        end
    end

    // Output holding register. A fresh estimate always takes priority over
    // the consumer's handshake, so a completion during a handshake keeps valid high.
    always_comb begin
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        if (last) begin
            out_value_d = diff;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_p_q   <= '0;
            count_m_q   <= '0;
            idx_q       <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_p_q   <= count_p_d;
            count_m_q   <= count_m_d;
            idx_q       <= idx_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;

`ifdef BITSTREAM_DECODER_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;

    // Sticky: set when a completion overwrites an estimate the consumer has not taken.
    always_comb begin
        overrun_d = overrun_q | (last && out_valid_q && !out_ready);
    end

    // Overrun flag register, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: directed scenarios plus randomized traffic for
// bitstream_decoder (WINDOW_LOG2 = 4). The reference model tracks only the
// running net sum and the number of accepted samples in the current window.
module tb_bitstream_decoder;

    localparam int unsigned WL  = 4;
    localparam int          Win = 1 << WL;
`ifdef BITSTREAM_DECODER_OVERRUN_FLAG_EN
    localparam bit OvrEn = 1'b1;
`else
    localparam bit OvrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_p = 1'b0;
    logic          in_m = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [WL+1:0] out_value;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_sum   = 0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;
    int m_value = 0;
    bit m_ovr   = 1'b0;
    bit m_rst   = 1'b0;

    bitstream_decoder #(
        .WINDOW_LOG2(WL)
    ) u_dut (
        .CLK      (clk),
        .nRST     (n_rst),
        .in_valid (in_valid),
        .in_p     (in_p),
        .in_m     (in_m),
        .clear    (clear),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_value(out_value),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then
    // compare all outputs 1 time unit after the edge.
    task automatic step(input bit v, input bit p, input bit m, input bit c, input bit r,
                        input bit rst_n);
        bit done;
        int est;
        in_valid  = v;
        in_p      = p;
        in_m      = m;
        clear     = c;
        out_ready = r;
        n_rst     = rst_n;
        @(posedge clk);
        done = 1'b0;
        est  = 0;
        if (!rst_n) begin
            m_sum = 0; m_cnt = 0; m_valid = 1'b0; m_value = 0; m_ovr = 1'b0;
            m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (c) begin
                m_sum = 0;
                m_cnt = 0;
            end else if (v) begin
                m_sum = m_sum + int'(p) - int'(m);
                m_cnt++;
                if (m_cnt == Win) begin
                    done  = 1'b1;
                    est   = m_sum;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            if (done) begin
                if (m_valid && !r && OvrEn) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_value = est;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", int'(out_valid), int'(m_valid));
        check("overrun", int'(overrun), int'(m_ovr));
        if (m_valid || m_rst) check("out_value", int'($signed(out_value)), m_value);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_value", int'($signed(out_value)), 0);

        // +16 from a full window of in_p
        for (int i = 0; i < Win; i++) step(1, 1, 0, 0, 0, 1);
        check("full_p_valid", int'(out_valid), 1);
        check("full_p_value", int'($signed(out_value)), 16);
        step(0, 0, 0, 0, 1, 1);

        // -16 with in_valid toggling: 16 accepted samples over 32 cycles
        for (int i = 0; i < 2 * Win; i++) begin
            step(bit'((i % 2) == 0), 0, 1, 0, 0, 1);
            if (i == 2 * Win - 3) check("no_early_done", int'(out_valid), 0);
        end
        check("full_m_value", int'(out_value), 6'b110000);
        step(0, 0, 0, 0, 1, 1);

        // +4, out_ready held high so out_valid lasts exactly one cycle
        for (int i = 0; i < Win; i++) step(1, bit'((i % 2) == 0), bit'(i < 4), 0, 1, 1);
        check("mix_value", int'($signed(out_value)), 4);
        step(0, 0, 0, 0, 1, 1);
        check("mix_valid_drop", int'(out_valid), 0);

        // Two windows unconsumed: +16 then +8 overwrites
        for (int i = 0; i < 2 * Win; i++) step(1, bit'(i < Win + 8), 0, 0, 0, 1);
        check("ovr_value", int'($signed(out_value)), 8);
        check("ovr_flag", int'(overrun), int'(OvrEn));
        step(0, 0, 0, 0, 1, 1);

        // clear on the 10th sample discards the partial window
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 1, 1);
        for (int i = 0; i < Win; i++) begin
            step(1, 1, 0, 0, 1, 1);
            if (i == 6) check("clr_no_done", int'(out_valid), 0);
        end
        check("clr_value", int'($signed(out_value)), 16);

        // Reset mid-window while an estimate is pending
        for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_value", int'($signed(out_value)), 0);
        check("midrst_ovr", int'(overrun), 0);
        for (int i = 0; i < Win; i++) step(1, 1, 1, 0, 0, 1);
        check("midrst_done", int'(out_valid), 1);
        check("midrst_net0", int'($signed(out_value)), 0);
        step(0, 0, 0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(bit'($urandom_range(3) != 0), bit'($urandom_range(1)), bit'($urandom_range(1)),
                 bit'($urandom_range(63) == 0), bit'($urandom_range(2) != 0),
                 bit'($urandom_range(499) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitstream_decoder.md
BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 8, meaning log2 of accepted samples per estimation window (range 1..16).
REQ-002 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port nRST  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  current in_p/in_m sample is accepted this cycle.
REQ-005 SHALL have port in_p  input  1  positive-channel stochastic bit from the upstream generator.
REQ-006 SHALL have port in_m  input  1  negative-channel stochastic bit from the upstream generator.
REQ-007 SHALL have port clear  input  1  synchronous window restart; discards partial counts.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_value this cycle.
REQ-009 SHALL have port out_valid  output  1  out_value holds an unconsumed estimate.
REQ-010 SHALL have port out_value  output  WINDOW_LOG2+2  two's-complement estimate, count_p minus count_m over one window.
REQ-011 SHALL have port overrun  output  1  sticky flag: an unconsumed estimate was overwritten.

Function
REQ-012 SHALL keep count_p and count_m, each WINDOW_LOG2+1 bits unsigned, and sample counter idx, WINDOW_LOG2 bits.
REQ-013 When in_valid=1 and clear=0: count_p += in_p, count_m += in_m, idx += 1 (wraps to 0 after 2^WINDOW_LOG2-1).
REQ-014 When in_valid=0: counters and idx unchanged.
REQ-015 in_p=in_m=1 in one sample SHALL increment both counters (net contribution zero).
REQ-016 Accepting the sample at idx=2^WINDOW_LOG2-1 (cycle t) SHALL complete the window: at t+1 out_value = signed(count_p_final) - signed(count_m_final), out_valid=1, counters/idx = 0.
REQ-017 Completion latency: exactly one cycle from accepting the last sample to out_valid/out_value update.
REQ-018 Arithmetic range: full window of in_p=1 gives +2^WINDOW_LOG2; full in_m=1 gives -2^WINDOW_LOG2; no saturation or overflow possible.
REQ-019 out_valid SHALL stay 1 and out_value stable until a cycle with out_ready=1; out_valid falls the following cycle unless a new window completes at the same time.
REQ-020 Window completion in the same cycle as out_valid&&out_ready: new estimate loaded, out_valid stays 1, overrun unaffected.
REQ-021 Window completion while out_valid=1 and out_ready=0: new estimate overwrites out_value, out_valid stays 1, overrun event raised (see REQ-027).
REQ-022 clear=1 SHALL zero count_p, count_m, idx next cycle, regardless of in_valid; clear coincident with the last sample SHALL suppress that completion (clear wins).
REQ-023 clear SHALL NOT affect out_valid, out_value or overrun.
REQ-024 Windows run back-to-back: the sample accepted the cycle after completion is sample 0 of the next window.

Reset
REQ-025 nRST=0 at a rising edge SHALL set count_p, count_m, idx, out_value to 0, out_valid to 0, overrun to 0; takes priority over all inputs, including mid-window.
REQ-026 First window after reset release starts at the first accepted sample.

Configuration
REQ-027 Macro BITSTREAM_DECODER_OVERRUN_FLAG_EN: defined -> overrun set to 1 on any REQ-021 event and held until reset; undefined -> overrun tied to 0 and no overrun register synthesized; all other behaviour identical.

Verification
REQ-028 WINDOW_LOG2=4, in_valid=1, in_p=1, in_m=0 for 16 cycles -> out_valid=1 one cycle after 16th sample, out_value=+16.
REQ-029 WINDOW_LOG2=4, in_m=1, in_p=0 for 16 samples, in_valid toggling 1/0 -> completion only after 16th accepted sample, out_value=-16 (6'b110000).
REQ-030 WINDOW_LOG2=4, in_p alternating 1/0 and in_m=1 on samples 0-3, out_ready=1 -> out_value=+4, out_valid high exactly one cycle.
REQ-031 out_ready=0 for two consecutive windows (+16 then +8) -> out_value=+8, out_valid=1, overrun=1 with macro, 0 without.
REQ-032 clear=1 at 10th sample, then 16 more samples in_p=1 -> no completion from first partial window, then out_value=+16.
REQ-033 nRST=0 for one cycle at sample 7 with out_valid=1 -> next cycle out_valid=0, out_value=0, overrun=0; next completion 16 accepted samples later.
